spi_master_multi: RTL and testbench
===================================

// Module: spi_master_multi
// PURPOSE
//  Parametrised SPI master. Supports runtime-selectable SPI mode (CPOL/CPHA), runtime clock divider and
//  NUM_CS chip selects. Performs a single transfer of total_len bits: the first TO_SPI_BITS bits go out
//  MSB first, then 0s; all sampled MISO bits shift into a FROM_SPI_BITS capture register.
//  Sits between a register/peripheral bus and external SPI devices (ADCs, drivers, flash).
// PARAMETERS
//  TO_SPI_BITS    8  width of transmit word
//  FROM_SPI_BITS  8  width of receive word (holds last FROM_SPI_BITS sampled bits)
//  NUM_CS         4  number of active-low chip selects
//  DIV_WIDTH      8  width of half_div
// PORTS
//  clk            in   1                 system clock; all logic on posedge
//  reset          in   1                 asynchronous, active-high reset
//  stb_wr         in   1                 start strobe; accepted only when busy=0
//  cs_sel         in   clog2(NUM_CS)     chip select index, latched on accepted stb_wr
//  cpol           in   1                 clock idle level, latched on accepted stb_wr
//  cpha           in   1                 0: sample leading edge; 1: sample trailing edge
//  half_div       in   DIV_WIDTH         SCLK half-period in clk cycles (H); 0 treated as 1
//  total_len      in   clog2(TO+FROM+1)  bits to clock, latched on accepted stb_wr
//  to_spi_data    in   TO_SPI_BITS       transmit word, latched on accepted stb_wr
//  from_spi_data  out  FROM_SPI_BITS     receive register; valid from stb_rdy until next accepted stb_wr
//  busy           out  1                 transfer in progress
//  stb_rdy        out  1                 one-cycle pulse at end of transfer
//  spi_clk        out  1                 SCLK
//  spi_mosi       out  1                 MOSI
//  spi_miso       in   1                 MISO
//  spi_cs_n       out  NUM_CS            active-low selects; at most one low at a time
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, stb_rdy=0, spi_cs_n=all 1, spi_clk=0, spi_mosi=0, from_spi_data=0.
//  All outputs are registered. In IDLE, spi_clk follows the cpol input, registered one cycle.
//  FSM: IDLE -> SETUP -> XFER -> HOLD -> IDLE. H = max(half_div,1); a half-period counter runs in each
//  non-IDLE state.
//  IDLE: stb_wr at cycle T latches all inputs. At T+1: busy=1, spi_cs_n[cs_sel]=0, spi_mosi=to_spi MSB.
//  SETUP: lasts H cycles with spi_clk=cpol; then goes to XFER (or to HOLD if total_len==0).
//  XFER: 2*total_len half-periods of H cycles each; spi_clk toggles at each half-period boundary.
//   Leading edge = first toggle of each bit; trailing edge = second toggle.
//   cpha=0: sample MISO on the leading edge; shift MOSI on the trailing edge (first bit valid from SETUP).
//   cpha=1: shift MOSI on the leading edge (except the first bit); sample MISO on the trailing edge.
//   Sample = from <= {from[FROM-2:0], spi_miso}, using the spi_miso value registered on the edge cycle.
//   After TO_SPI_BITS bits have been shifted out, spi_mosi=0.
//   Goes to HOLD after the final trailing edge (spi_clk is back at cpol).
//  HOLD: lasts H cycles with spi_clk=cpol. In the last HOLD cycle spi_cs_n returns to all 1 and
//   stb_rdy=1; on the next cycle busy=0 and state=IDLE.
//  Timing: CS low for exactly (2*total_len+2)*H cycles. A new stb_wr is accepted in the cycle after
//   stb_rdy.
//  stb_wr while busy=1: ignored; no latched state changes.
//  cs_sel >= NUM_CS: transfer runs normally, no CS asserted.
//  total_len==0: CS low for 2H cycles, no SCLK edges, stb_rdy pulses, from_spi unchanged.
//  total_len > TO+FROM: saturate to TO+FROM.
//  half_div, cpol and cpha changes during busy have no effect (latched values are used).
//  Reset mid-transfer: return immediately to the reset values; no stb_rdy pulse.
// TESTING
//  1 Mode0, H=2, len=8, tx=8'hA5, slave loopback MISO=MOSI -> SCLK 8 pulses, CS low 36 cyc,
//    rx=8'hA5, stb_rdy x1.
//  2 Mode3 (cpol=1,cpha=1), H=3, len=8, slave returns 8'h3C -> SCLK idles high, rx=8'h3C,
//    MOSI sampled by model = tx.
//  3 len=16, tx=8'h9F, slave drives 8'hC2 on bits 8-15 -> MOSI=0 after bit 8, rx=8'hC2,
//    CS low (32+2)*H cycles.
//  4 stb_wr pulsed mid-transfer with different data/cs_sel -> ignored; original transfer
//    completes unchanged.
//  5 half_div=0, len=0, cs_sel=NUM_CS -> all CS high, no SCLK edge, stb_rdy 3 cycles after stb_wr.
//  6 reset asserted during XFER bit 4 -> outputs at reset values next edge; no stb_rdy;
//    next transfer is correct.

Source files
------------

// File: rtl/spi_master_multi.sv
// -----------------------------------------------------------------------------
// spi_master_multi
//
// Parametrised SPI master with runtime-selectable mode (cpol/cpha), runtime
// SCLK divider and NUM_CS active-low chip selects. One accepted stb_wr clocks
// total_len bits: the first TO_SPI_BITS go out MSB first, then zeros. Every
// sampled MISO bit shifts into from_spi_data, which keeps the last
// FROM_SPI_BITS bits.
//
// Ports
//   clk            system clock, all logic on posedge
//   reset          asynchronous, active-high reset
//   stb_wr         start strobe, accepted only while busy=0
//   cs_sel         chip select index (>= NUM_CS selects nothing)
//   cpol, cpha     SPI mode, latched at start
//   half_div       SCLK half-period in clk cycles (0 behaves as 1)
//   total_len      bits to clock, saturated to TO_SPI_BITS+FROM_SPI_BITS
//   to_spi_data    transmit word
//   from_spi_data  receive register, valid from stb_rdy to next accepted stb_wr
//   busy           transfer in progress (also high during the stb_rdy cycle)
//   stb_rdy        one-cycle end-of-transfer pulse
//   spi_clk        SCLK
//   spi_mosi       MOSI
//   spi_miso       MISO
//   spi_cs_n       active-low chip selects, at most one low
//
// Frame: SETUP (H cycles, SCLK idle) -> XFER (2*len half-periods of H cycles)
// -> HOLD (H cycles, SCLK idle). SCLK takes its new level at the start of
// each XFER half-period: even half-periods begin with a leading edge, odd
// ones with a trailing edge.
// -----------------------------------------------------------------------------
module spi_master_multi #(
  parameter int TO_SPI_BITS   = 8,
  parameter int FROM_SPI_BITS = 8,
  parameter int NUM_CS        = 4,
  parameter int DIV_WIDTH     = 8,
  localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  localparam int LEN_W = $clog2(TO_SPI_BITS + FROM_SPI_BITS + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stb_wr,
  input  logic [CS_W-1:0]          cs_sel,
  input  logic                     cpol,
  input  logic                     cpha,
  input  logic [DIV_WIDTH-1:0]     half_div,
  input  logic [LEN_W-1:0]         total_len,
  input  logic [TO_SPI_BITS-1:0]   to_spi_data,
  output logic [FROM_SPI_BITS-1:0] from_spi_data,
  output logic                     busy,
  output logic                     stb_rdy,
  output logic                     spi_clk,
  output logic                     spi_mosi,
  input  logic                     spi_miso,
  output logic [NUM_CS-1:0]        spi_cs_n
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(TO_SPI_BITS + FROM_SPI_BITS);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t                 state;
  logic [DIV_WIDTH-1:0]   h_q;
  logic [DIV_WIDTH-1:0]   cnt;
  logic [LEN_W-1:0]       len_q;
  logic [LEN_W:0]         half_idx;
  logic                   cpol_q;
  logic                   cpha_q;
  logic [TO_SPI_BITS-1:0] tx_sr;
  logic                   miso_q;
  logic                   sample_pend;

  // Values captured at an accepted stb_wr.
  logic [DIV_WIDTH-1:0]   h_in;
  logic [LEN_W-1:0]       len_in;
  logic [NUM_CS-1:0]      cs_dec;

  assign h_in   = (half_div == '0) ? DIV_WIDTH'(1) : half_div;
  assign len_in = (total_len > MAX_LEN) ? MAX_LEN : total_len;

  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_sel == CS_W'(i)) cs_dec[i] = 1'b0;
    end
  end

  // Half-period bookkeeping.
  logic           half_end;
  logic [LEN_W:0] last_half;
  logic [LEN_W:0] next_half;

  assign half_end  = (cnt == h_q - 1'b1);
  assign last_half = {len_q, 1'b0} - 1'b1;
  assign next_half = half_idx + 1'b1;

  // SCLK edge decode for the edge produced at this clk edge.
  logic go_lead;
  logic go_trail;
  logic first_bit;
  logic sample_edge;
  logic shift_edge;

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    go_lead   = 1'b0;
    go_trail  = 1'b0;
    first_bit = 1'b0;
    if (half_end) begin
      if (state == SETUP && len_q != '0) begin
        go_lead   = 1'b1;
        first_bit = 1'b1;
      end else if (state == XFER && half_idx != last_half) begin
        go_lead  = ~next_half[0];
        go_trail = next_half[0];
      end
    end
  end

  // cpha=1 never shifts on the first leading edge: bit 0 is already on MOSI.
  assign sample_edge = cpha_q ? go_trail : go_lead;
  assign shift_edge  = cpha_q ? (go_lead & ~first_bit) : go_trail;

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      stb_rdy       <= 1'b0;
      spi_cs_n      <= '1;
      spi_clk       <= 1'b0;
      spi_mosi      <= 1'b0;
      from_spi_data <= '0;
      h_q           <= DIV_WIDTH'(1);
      cnt           <= '0;
      len_q         <= '0;
      half_idx      <= '0;
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      tx_sr         <= '0;
      miso_q        <= 1'b0;
      sample_pend   <= 1'b0;
    end else begin
      miso_q      <= spi_miso;
      stb_rdy     <= 1'b0;
      sample_pend <= sample_edge;

      // Shift uses MISO as registered on the edge cycle, one cycle later.
      if (sample_pend) begin
        from_spi_data <= {from_spi_data[FROM_SPI_BITS-2:0], miso_q};
      end

      if (go_lead || go_trail) spi_clk <= ~spi_clk;

      // Zero fill of tx_sr drives MOSI low once the transmit word is spent.
      if (shift_edge) begin
        spi_mosi <= tx_sr[TO_SPI_BITS-1];
        tx_sr    <= tx_sr << 1;
      end

      case (state)
        IDLE: begin
          busy    <= 1'b0;
          spi_clk <= cpol;
          cnt     <= '0;
          // busy is still high during the stb_rdy cycle, so a strobe there
          // is ignored and the next one is accepted a cycle later.
          if (stb_wr && !busy) begin
            busy     <= 1'b1;
            spi_cs_n <= cs_dec;
            spi_mosi <= to_spi_data[TO_SPI_BITS-1];
            tx_sr    <= to_spi_data << 1;
            h_q      <= h_in;
            len_q    <= len_in;
            cpol_q   <= cpol;
            cpha_q   <= cpha;
            state    <= SETUP;
          end
        end

        SETUP: begin
          if (half_end) begin
            cnt      <= '0;
            half_idx <= '0;
            state    <= (len_q == '0) ? HOLD : XFER;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        XFER: begin
          if (half_end) begin
            cnt <= '0;
            if (half_idx == last_half) state <= HOLD;
            else                       half_idx <= next_half;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        HOLD: begin
          if (half_end) begin
            cnt      <= '0;
            spi_cs_n <= '1;
            spi_mosi <= 1'b0;
            stb_rdy  <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_multi.sv
// -----------------------------------------------------------------------------
// tb_spi_master_multi
//
// Directed bench for spi_master_multi (NUM_CS=3 so cs_sel can address a
// non-existent select). A behavioural SPI slave follows the configured mode,
// drives a programmed MISO pattern (or loops MOSI back) and records MOSI.
// Stimulus pushes hand-computed expectations into a scoreboard queue; a
// monitor pops and compares whenever stb_rdy is seen.
// -----------------------------------------------------------------------------
module tb_spi_master_multi;

  localparam int NUM_CS = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        stb_wr;
  logic [1:0]  cs_sel;
  logic        cpol;
  logic        cpha;
  logic [7:0]  half_div;
  logic [4:0]  total_len;
  logic [7:0]  to_spi_data;
  logic [7:0]  from_spi_data;
  logic        busy;
  logic        stb_rdy;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso;
  logic [NUM_CS-1:0] spi_cs_n;

  spi_master_multi #(
    .TO_SPI_BITS  (8),
    .FROM_SPI_BITS(8),
    .NUM_CS       (NUM_CS),
    .DIV_WIDTH    (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stb_wr       (stb_wr),
    .cs_sel       (cs_sel),
    .cpol         (cpol),
    .cpha         (cpha),
    .half_div     (half_div),
    .total_len    (total_len),
    .to_spi_data  (to_spi_data),
    .from_spi_data(from_spi_data),
    .busy         (busy),
    .stb_rdy      (stb_rdy),
    .spi_clk      (spi_clk),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .spi_cs_n     (spi_cs_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural slave ----------------
  logic        s_cpol = 1'b0;
  logic        s_cpha = 1'b0;
  logic [15:0] s_tx   = '0;
  logic [31:0] s_rx   = '0;
  int          s_bit  = 0;
  logic        s_drive = 1'b0;
  logic        loopback = 1'b0;

  assign spi_miso = loopback ? spi_mosi : s_drive;

  function automatic logic bit_at(input int i);
    return (i < 16) ? s_tx[15 - i] : 1'b0;
  endfunction

  always @(spi_clk) begin
    if (busy) begin
      if (spi_clk !== s_cpol) begin
        if (s_cpha) s_drive = bit_at(s_bit);
        else        s_rx = {s_rx[30:0], spi_mosi};
      end else begin
        if (s_cpha) begin
          s_rx = {s_rx[30:0], spi_mosi};
          s_bit++;
        end else begin
          s_bit++;
          s_drive = bit_at(s_bit);
        end
      end
    end
  end

  // ---------------- scoreboard + monitor ----------------
  typedef struct {
    logic [7:0]  rx;
    logic [15:0] mosi;
    int          cs_low;
    logic [2:0]  mask;
    int          edges;
    int          lat;
    int          issue;
  } exp_t;

  exp_t sb[$];

  int         cs_low_cnt = 0;
  int         edge_cnt   = 0;
  logic [2:0] cs_seen    = '0;
  logic       multi_cs   = 1'b0;
  logic       prev_clk   = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      cs_low_cnt = 0;
      edge_cnt   = 0;
      cs_seen    = '0;
      multi_cs   = 1'b0;
    end else begin
      if (spi_cs_n != '1) cs_low_cnt++;
      cs_seen = cs_seen | ~spi_cs_n;
      if ($countones(~spi_cs_n) > 1) multi_cs = 1'b1;
      if (busy && spi_clk !== prev_clk) edge_cnt++;
      if (stb_rdy) begin
        if (sb.size() == 0) begin
          check("unexpected_stb_rdy", {31'd0, stb_rdy}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rx_data", {24'd0, from_spi_data}, {24'd0, e.rx});
          check("cs_low_cycles", cs_low_cnt, e.cs_low);
          check("cs_asserted", {29'd0, cs_seen}, {29'd0, e.mask});
          check("cs_onehot", {31'd0, multi_cs}, 32'd0);
          check("sclk_edges", edge_cnt, e.edges);
          check("rdy_latency", cyc - e.issue, e.lat);
          if (e.edges > 0) begin
            logic [31:0] m;
            m = (32'h1 << (e.edges / 2)) - 32'h1;
            check("mosi_seen", s_rx & m, {16'd0, e.mosi});
          end
        end
        cs_low_cnt = 0;
        edge_cnt   = 0;
        cs_seen    = '0;
        multi_cs   = 1'b0;
      end
    end
    prev_clk = spi_clk;
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic        cpol;
    logic        cpha;
    logic [7:0]  hdiv;
    logic [4:0]  len;
    logic [7:0]  tx;
    logic [1:0]  cs;
    logic        loop;
    logic [15:0] stx;
    logic [7:0]  rx;
    logic [15:0] mosi;
    int          cs_low;
    logic [2:0]  mask;
    int          edges;
    int          lat;
  } vec_t;

  task automatic issue(input vec_t v, input bit push);
    exp_t e;
    cpol        = v.cpol;
    cpha        = v.cpha;
    half_div    = v.hdiv;
    total_len   = v.len;
    to_spi_data = v.tx;
    cs_sel      = v.cs;
    s_cpol      = v.cpol;
    s_cpha      = v.cpha;
    s_tx        = v.stx;
    s_rx        = '0;
    s_bit       = 0;
    s_drive     = v.stx[15];
    loopback    = v.loop;
    repeat (2) @(negedge clk);
    check("sclk_idle_level", {31'd0, spi_clk}, {31'd0, v.cpol});
    if (push) begin
      e.rx     = v.rx;
      e.mosi   = v.mosi;
      e.cs_low = v.cs_low;
      e.mask   = v.mask;
      e.edges  = v.edges;
      e.lat    = v.lat;
      e.issue  = cyc;
      sb.push_back(e);
    end
    stb_wr = 1'b1;
    @(negedge clk);
    stb_wr = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", sb.size(), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    check("busy_clear", {31'd0, busy}, 32'd0);
  endtask

  vec_t t1, t2, t3, t4, t5, t6a, t6b, t7;
  int   saw_rdy;

  initial begin
    //          cpol  cpha  hdiv  len    tx     cs    loop  stx       rx     mosi      csl mask    edg lat
    t1  = '{1'b0, 1'b0, 8'd2, 5'd8,  8'hA5, 2'd0, 1'b1, 16'h0000, 8'hA5, 16'h00A5, 36, 3'b001, 16, 37};
    t2  = '{1'b1, 1'b1, 8'd3, 5'd8,  8'h5A, 2'd1, 1'b0, 16'h3C00, 8'h3C, 16'h005A, 54, 3'b010, 16, 55};
    t3  = '{1'b0, 1'b0, 8'd1, 5'd16, 8'h9F, 2'd2, 1'b0, 16'h55C2, 8'hC2, 16'h9F00, 34, 3'b100, 32, 35};
    t4  = '{1'b0, 1'b1, 8'd1, 5'd8,  8'hC3, 2'd2, 1'b0, 16'h9600, 8'h96, 16'h00C3, 18, 3'b100, 16, 19};
    t5  = '{1'b0, 1'b0, 8'd0, 5'd0,  8'hFF, 2'd3, 1'b0, 16'h0000, 8'h96, 16'h0000, 0,  3'b000, 0,  3};
    t7  = '{1'b0, 1'b0, 8'd1, 5'd20, 8'h81, 2'd1, 1'b0, 16'h0F5A, 8'h5A, 16'h8100, 34, 3'b010, 32, 35};
    t6a = '{1'b0, 1'b0, 8'd2, 5'd8,  8'hF0, 2'd1, 1'b0, 16'hFFFF, 8'h00, 16'h0000, 0,  3'b000, 0,  0};
    t6b = '{1'b0, 1'b0, 8'd2, 5'd8,  8'h3C, 2'd0, 1'b1, 16'h0000, 8'h3C, 16'h003C, 36, 3'b001, 16, 37};

    reset       = 1'b1;
    stb_wr      = 1'b0;
    cs_sel      = '0;
    cpol        = 1'b0;
    cpha        = 1'b0;
    half_div    = 8'd1;
    total_len   = '0;
    to_spi_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stb_rdy", {31'd0, stb_rdy}, 32'd0);
    check("rst_cs_n", {29'd0, spi_cs_n}, 32'h7);
    check("rst_sclk", {31'd0, spi_clk}, 32'd0);
    check("rst_mosi", {31'd0, spi_mosi}, 32'd0);
    check("rst_rx", {24'd0, from_spi_data}, 32'd0);

    issue(t1, 1'b1); wait_done();
    issue(t2, 1'b1); wait_done();
    check("sclk_idle_after_mode3", {31'd0, spi_clk}, 32'd1);
    issue(t3, 1'b1); wait_done();

    // Strobe with different settings in the middle of a transfer.
    issue(t4, 1'b1);
    repeat (5) @(negedge clk);
    stb_wr = 1'b1; to_spi_data = 8'hFF; cs_sel = 2'd0; half_div = 8'd5;
    total_len = 5'd3; cpol = 1'b1; cpha = 1'b0;
    @(negedge clk);
    stb_wr = 1'b0; to_spi_data = t4.tx; cs_sel = t4.cs; half_div = t4.hdiv;
    total_len = t4.len; cpol = t4.cpol; cpha = t4.cpha;
    wait_done();

    issue(t5, 1'b1); wait_done();
    issue(t7, 1'b1); wait_done();

    // Reset during bit 4 of XFER: no completion expected.
    issue(t6a, 1'b0);
    repeat (18) @(negedge clk);
    check("busy_before_abort", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_cs_n", {29'd0, spi_cs_n}, 32'h7);
    check("abort_sclk", {31'd0, spi_clk}, 32'd0);
    check("abort_mosi", {31'd0, spi_mosi}, 32'd0);
    check("abort_rx", {24'd0, from_spi_data}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    saw_rdy = 0;
    repeat (60) begin
      @(negedge clk);
      if (stb_rdy) saw_rdy++;
    end
    check("abort_no_stb_rdy", saw_rdy, 0);

    issue(t6b, 1'b1); wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
